tube_target: RTL and testbench

Tube bus responder: the target end of the 8-bit Tube strobe bus driven by the Wishbone Tube controller. It decodes `tube_cs_n`/`tube_rd_n`/`tube_wr_n`/`tube_adr` and serves reads and writes from two byte FIFOs: host→parasite (h2p) and parasite→host (p2h). A status register and level registers sit alongside the FIFOs. The local side exposes the FIFOs as valid/ready byte streams. It runs in the same clock domain as the initiator, so no strobe synchronisers are used.

---
 rtl/tube_target.sv | 127 ++++++++++++
 tb/tb_tube_target.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tube_target.sv
// Tube bus responder: serves the 8-bit strobe bus from two byte FIFOs.
// The local side sees h2p and p2h as valid/ready byte streams.
module tube_target #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] tube_adr,
    inout  wire  [7:0] tube_dat,
    input  logic       tube_cs_n,
    input  logic       tube_rd_n,
    input  logic       tube_wr_n,
    output logic [7:0] h2p_dat,
    output logic       h2p_valid,
    input  logic       h2p_ready,
    input  logic [7:0] p2h_dat,
    input  logic       p2h_valid,
    output logic       p2h_ready
);
    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned PtrW  = DEPTH_LOG2;
    localparam int unsigned LvlW  = DEPTH_LOG2 + 1;

    logic [7:0]      h2p_mem_q [Depth];
    logic [7:0]      p2h_mem_q [Depth];
    logic [PtrW-1:0] h2p_wptr_q, h2p_rptr_q, p2h_wptr_q, p2h_rptr_q;
    logic [LvlW-1:0] h2p_lvl_q, h2p_lvl_d, p2h_lvl_q, p2h_lvl_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic            act_q;
    logic [7:0]      rd_hold_q, rd_live;

    logic acc, rd, wr, start;
    logic h2p_full, h2p_push, h2p_pop, p2h_full, p2h_nempty, p2h_push, p2h_pop;
    logic ovf_set, unf_set, sts_clr;

    assign acc   = ~tube_cs_n & (tube_rd_n ^ tube_wr_n);
    assign rd    = acc & ~tube_rd_n;
    assign wr    = acc & ~tube_wr_n;
    assign start = acc & ~act_q;

    assign h2p_full   = (h2p_lvl_q == LvlW'(Depth));
    assign h2p_valid  = (h2p_lvl_q != '0);
    assign h2p_dat    = h2p_valid ? h2p_mem_q[h2p_rptr_q] : 8'h00;
    assign h2p_push   = start & wr & (tube_adr == 3'd1) & ~h2p_full;
    assign h2p_pop    = h2p_valid & h2p_ready;

    // Full is judged on the registered level, so a same-cycle bus pop cannot free a slot.
    assign p2h_full   = (p2h_lvl_q == LvlW'(Depth));
    assign p2h_nempty = (p2h_lvl_q != '0);
    assign p2h_ready  = ~p2h_full;
    assign p2h_push   = p2h_valid & p2h_ready;
    assign p2h_pop    = start & rd & (tube_adr == 3'd1) & p2h_nempty;

    assign ovf_set = start & wr & (tube_adr == 3'd1) & h2p_full;
    assign unf_set = start & rd & (tube_adr == 3'd1) & ~p2h_nempty;
    assign sts_clr = start & rd & (tube_adr == 3'd0);

    always_comb begin
        h2p_lvl_d = h2p_lvl_q;
        if (h2p_push && !h2p_pop) begin
            h2p_lvl_d = h2p_lvl_q + LvlW'(1);
        end else if (!h2p_push && h2p_pop) begin
            h2p_lvl_d = h2p_lvl_q - LvlW'(1);
        end
        p2h_lvl_d = p2h_lvl_q;
        if (p2h_push && !p2h_pop) begin
            p2h_lvl_d = p2h_lvl_q + LvlW'(1);
        end else if (!p2h_push && p2h_pop) begin
            p2h_lvl_d = p2h_lvl_q - LvlW'(1);
        end
        // Set is applied after clear so a coincident set survives.
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (sts_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (ovf_set) ovf_d = 1'b1;
        if (unf_set) unf_d = 1'b1;
    end

    always_comb begin
        rd_live = 8'hFF;
        unique case (tube_adr)
            3'd0:    rd_live = {p2h_nempty, ~h2p_full, 4'b0000, ovf_q, unf_q};
            3'd1:    rd_live = p2h_nempty ? p2h_mem_q[p2h_rptr_q] : 8'h00;
            3'd2:    rd_live = 8'(p2h_lvl_q);
            3'd3:    rd_live = 8'(h2p_lvl_q);
            default: rd_live = 8'hFF;
        endcase
    end

    // After the first edge the pop/clear has landed, so the captured value is replayed.
    assign tube_dat = rd ? (start ? rd_live : rd_hold_q) : 8'hzz;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h2p_wptr_q <= '0;
            h2p_rptr_q <= '0;
            p2h_wptr_q <= '0;
            p2h_rptr_q <= '0;
            h2p_lvl_q  <= '0;
            p2h_lvl_q  <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            act_q      <= 1'b1;
            rd_hold_q  <= 8'h00;
        end else begin
            if (h2p_push) h2p_wptr_q <= h2p_wptr_q + PtrW'(1);
            if (h2p_pop)  h2p_rptr_q <= h2p_rptr_q + PtrW'(1);
            if (p2h_push) p2h_wptr_q <= p2h_wptr_q + PtrW'(1);
            if (p2h_pop)  p2h_rptr_q <= p2h_rptr_q + PtrW'(1);
            h2p_lvl_q <= h2p_lvl_d;
            p2h_lvl_q <= p2h_lvl_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            act_q     <= acc;
            if (start) rd_hold_q <= rd_live;
        end
    end

    always_ff @(posedge clk) begin
        if (h2p_push) h2p_mem_q[h2p_wptr_q] <= tube_dat;
        if (p2h_push) p2h_mem_q[p2h_wptr_q] <= p2h_dat;
    end

endmodule

// File: tb/tb_tube_target.sv
// Directed bench for tube_target: bus reads/writes, local streams, sticky bits, reset mid-access.
module tb_tube_target;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] tube_adr;
    wire  [7:0] tube_dat;
    logic       tube_cs_n, tube_rd_n, tube_wr_n;
    logic [7:0] h2p_dat;
    logic       h2p_valid, h2p_ready;
    logic [7:0] p2h_dat;
    logic       p2h_valid, p2h_ready;
    logic [7:0] drv_dat;
    logic       drv_oe;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] rdat;

    assign tube_dat = drv_oe ? drv_dat : 8'hzz;

    tube_target #(.DEPTH_LOG2(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tube_adr  (tube_adr),
        .tube_dat  (tube_dat),
        .tube_cs_n (tube_cs_n),
        .tube_rd_n (tube_rd_n),
        .tube_wr_n (tube_wr_n),
        .h2p_dat   (h2p_dat),
        .h2p_valid (h2p_valid),
        .h2p_ready (h2p_ready),
        .p2h_dat   (p2h_dat),
        .p2h_valid (p2h_valid),
        .p2h_ready (p2h_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; samples lat cycles into the strobe.
    task automatic bus_read(input logic [2:0] adr, input int lat, output logic [7:0] d);
        tube_adr  = adr;
        tube_cs_n = 1'b0;
        tube_rd_n = 1'b0;
        repeat (lat) @(posedge clk);
        @(negedge clk);
        d = tube_dat;
        @(posedge clk); #1;
        tube_cs_n = 1'b1;
        tube_rd_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input logic [2:0] adr, input logic [7:0] d, input int hold);
        tube_adr  = adr;
        drv_dat   = d;
        drv_oe    = 1'b1;
        tube_cs_n = 1'b0;
        tube_wr_n = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        tube_cs_n = 1'b1;
        tube_wr_n = 1'b1;
        drv_oe    = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b0; tube_adr = 3'd0; tube_cs_n = 1'b1; tube_rd_n = 1'b1;
        tube_wr_n = 1'b1; h2p_ready = 1'b0; p2h_dat = 8'h00; p2h_valid = 1'b0;
        drv_dat = 8'h00; drv_oe = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("idle_z", {7'd0, tube_dat === 8'hzz}, 8'h01);
        check("rst_p2h_ready", {7'd0, p2h_ready}, 8'h01);
        check("rst_h2p_valid", {7'd0, h2p_valid}, 8'h00);
        check("rst_h2p_dat", h2p_dat, 8'h00);
        @(posedge clk); #1;
        bus_read(3'd0, 0, rdat); check("rst_status", rdat, 8'h40);
        bus_read(3'd2, 0, rdat); check("rst_p2h_lvl", rdat, 8'h00);
        bus_read(3'd3, 0, rdat); check("rst_h2p_lvl", rdat, 8'h00);
        bus_read(3'd5, 0, rdat); check("adr5_ff", rdat, 8'hFF);

        // Long write strobes push once each
        bus_write(3'd1, 8'hA5, 3);
        bus_write(3'd1, 8'h3C, 3);
        bus_read(3'd3, 0, rdat); check("h2p_lvl_2", rdat, 8'h02);
        h2p_ready = 1'b1;
        @(negedge clk); check("h2p_v0", {7'd0, h2p_valid}, 8'h01); check("h2p_d0", h2p_dat, 8'hA5);
        @(negedge clk); check("h2p_v1", {7'd0, h2p_valid}, 8'h01); check("h2p_d1", h2p_dat, 8'h3C);
        @(negedge clk); check("h2p_empty", {7'd0, h2p_valid}, 8'h00);
        @(posedge clk); #1 h2p_ready = 1'b0;

        // Local pushes read back at latency 0 and 7, then underflow
        p2h_valid = 1'b1; p2h_dat = 8'h11;
        @(posedge clk); #1 p2h_dat = 8'h22;
        @(posedge clk); #1 p2h_valid = 1'b0;
        bus_read(3'd2, 0, rdat); check("p2h_lvl_2", rdat, 8'h02);
        bus_read(3'd1, 0, rdat); check("p2h_rd_lat0", rdat, 8'h11);
        bus_read(3'd1, 7, rdat); check("p2h_rd_lat7", rdat, 8'h22);
        bus_read(3'd1, 0, rdat); check("p2h_rd_empty", rdat, 8'h00);
        bus_read(3'd0, 0, rdat); check("status_unf", rdat, 8'h41);
        bus_read(3'd0, 0, rdat); check("status_clr", rdat, 8'h40);

        // Overflow: 17 writes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) bus_write(3'd1, 8'(i), 1);
        bus_read(3'd3, 0, rdat); check("h2p_lvl_full", rdat, 8'h10);
        bus_read(3'd0, 0, rdat); check("status_ovf", rdat, 8'h02);
        h2p_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("drain_%0d", i), h2p_dat, 8'(i));
        end
        @(negedge clk); check("drain_done", {7'd0, h2p_valid}, 8'h00);
        @(posedge clk); #1 h2p_ready = 1'b0;

        // Fill p2h, then bus pop coincident with a local push
        p2h_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            p2h_dat = 8'h80 + 8'(i);
            @(posedge clk); #1;
        end
        p2h_valid = 1'b0;
        @(negedge clk); check("p2h_full_ready", {7'd0, p2h_ready}, 8'h00);
        @(posedge clk); #1;
        bus_read(3'd2, 0, rdat); check("p2h_lvl_full", rdat, 8'h10);
        tube_adr = 3'd1; tube_cs_n = 1'b0; tube_rd_n = 1'b0;
        p2h_valid = 1'b1; p2h_dat = 8'hEE;
        @(negedge clk);
        check("sim_rd", tube_dat, 8'h80);
        check("sim_ready_lo", {7'd0, p2h_ready}, 8'h00);
        @(posedge clk); #1 tube_cs_n = 1'b1; tube_rd_n = 1'b1;
        @(negedge clk); check("sim_ready_hi", {7'd0, p2h_ready}, 8'h01);
        @(posedge clk); #1 p2h_valid = 1'b0;
        @(negedge clk); check("sim_refull", {7'd0, p2h_ready}, 8'h00);
        @(posedge clk); #1;

        // Illegal access: both strobes low
        tube_adr = 3'd1; tube_cs_n = 1'b0; tube_rd_n = 1'b0; tube_wr_n = 1'b0;
        @(negedge clk); check("illegal_z0", {7'd0, tube_dat === 8'hzz}, 8'h01);
        @(negedge clk); check("illegal_z1", {7'd0, tube_dat === 8'hzz}, 8'h01);
        @(posedge clk); #1 tube_cs_n = 1'b1; tube_rd_n = 1'b1; tube_wr_n = 1'b1;
        @(posedge clk); #1;
        bus_read(3'd2, 0, rdat); check("illegal_lvl", rdat, 8'h10);
        bus_read(3'd0, 0, rdat); check("illegal_status", rdat, 8'hC0);
        for (int i = 1; i < 16; i++) begin
            bus_read(3'd1, 0, rdat);
            check($sformatf("p2h_drain_%0d", i), rdat, 8'h80 + 8'(i));
        end
        bus_read(3'd1, 0, rdat); check("p2h_drain_ee", rdat, 8'hEE);
        bus_read(3'd2, 0, rdat); check("p2h_lvl_0", rdat, 8'h00);

        // Reset during a held read; strobe still low at release
        tube_adr = 3'd1; tube_cs_n = 1'b0; tube_rd_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1; p2h_valid = 1'b1; p2h_dat = 8'h5A;
        @(posedge clk); #1 p2h_valid = 1'b0;
        @(posedge clk); #1 tube_cs_n = 1'b1; tube_rd_n = 1'b1;
        @(posedge clk); #1;
        bus_read(3'd0, 0, rdat); check("rst_mid_status", rdat, 8'hC0);
        bus_read(3'd2, 0, rdat); check("rst_mid_lvl", rdat, 8'h01);
        bus_read(3'd1, 0, rdat); check("rst_mid_pop", rdat, 8'h5A);
        bus_read(3'd2, 0, rdat); check("rst_mid_lvl0", rdat, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
